// File: rtl/cnn_stage_sequencer.sv
// Frame-level sequencer for the four CNN layer stages: RUN/GAP per stage, watchdog, done channel.
// Optional macro CNN_SEQ_PERF_EN adds the perf_cycles frame-latency output.
module cnn_stage_sequencer #(
    parameter int GAP_CYCLES  = 2,
    parameter int WDOG_CYCLES = 2047,
    parameter int WDOG_W      = 12
) (
    input  logic        S_AXIS_ACLK,
    input  logic        S_AXIS_ARESETN,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        abort,
    input  logic [3:0]  to_i,
    output logic [3:0]  en_o,
    output logic [2:0]  stage_o,
    output logic        busy,
    output logic        m_done_valid,
    input  logic        m_done_ready,
    output logic        m_done_err
`ifdef CNN_SEQ_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_stage, w_stage_nxt;
    logic [WDOG_W-1:0]   r_wdog,  w_wdog_nxt;
    logic [GAP_W-1:0]    r_gap,   w_gap_nxt;
    logic                r_err,   w_err_nxt;
    logic                r_start_ready;
    logic                w_to_hit;
    logic                w_wdog_exp;
    logic                w_start_hs;

    assign w_to_hit   = to_i[r_stage];
    assign w_wdog_exp = (r_wdog >= WDOG_W'(WDOG_CYCLES - 1));
    assign w_start_hs = start_valid & r_start_ready;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            r_state       <= S_IDLE;
            r_stage       <= 2'd0;
            r_wdog        <= '0;
            r_gap         <= '0;
            r_err         <= 1'b0;
            r_start_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage       <= w_stage_nxt;
            r_wdog        <= w_wdog_nxt;
            r_gap         <= w_gap_nxt;
            r_err         <= w_err_nxt;
            r_start_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // abort is evaluated first so it overrides every other transition in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_wdog_nxt  = r_wdog;
        w_gap_nxt   = r_gap;
        w_err_nxt   = r_err;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_stage_nxt = 2'd0;
            w_wdog_nxt  = '0;
            w_gap_nxt   = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_hs) begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = 2'd0;
                        w_wdog_nxt  = '0;
                    end
                end
                S_RUN: begin
                    if (w_to_hit) begin
                        w_wdog_nxt = '0;
                        w_gap_nxt  = '0;
                        if (r_stage == 2'd3) begin
                            w_state_nxt = S_DONE;
                            w_err_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end else if (w_wdog_exp) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        w_wdog_nxt  = '0;
                    end else if (r_wdog != '1) begin
                        w_wdog_nxt = r_wdog + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = r_stage + 2'd1;
                        w_wdog_nxt  = '0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                S_DONE: begin
                    if (m_done_ready) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign en_o         = (r_state == S_RUN) ? (4'b0001 << r_stage) : 4'b0000;
    assign stage_o      = (r_state == S_RUN) ? ({1'b0, r_stage} + 3'd1) : 3'd0;
    assign busy         = (r_state != S_IDLE);
    assign m_done_valid = (r_state == S_DONE);
    assign m_done_err   = r_err;

`ifdef CNN_SEQ_PERF_EN
    logic [15:0] r_pcnt;
    logic [15:0] r_perf;
    logic [15:0] w_pcnt_inc;

    assign w_pcnt_inc = (r_pcnt == 16'hFFFF) ? r_pcnt : (r_pcnt + 16'd1);

    // r_pcnt counts edges already spent in RUN/GAP; the DONE edge itself adds the final one
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            r_pcnt <= 16'd0;
            r_perf <= 16'd0;
        end else begin
            if (r_state == S_IDLE && w_start_hs && !abort) begin
                r_pcnt <= 16'd0;
            end else if (r_state == S_RUN || r_state == S_GAP) begin
                r_pcnt <= w_pcnt_inc;
            end
            if (r_state == S_RUN && w_state_nxt == S_DONE) begin
                r_perf <= w_pcnt_inc;
            end
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Directed bench for cnn_stage_sequencer with a stage-timer model (thresholds 70/31/1/1085).
module tb_cnn_stage_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic       abort = 1'b0;
    logic [3:0] to_i;
    logic [3:0] en_o;
    logic [2:0] stage_o;
    logic       busy;
    logic       m_done_valid;
    logic       m_done_ready = 1'b0;
    logic       m_done_err;
`ifdef CNN_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0]  model_mask = 4'hF;
    logic [3:0]  to_force = 4'h0;
    logic [11:0] tcnt = 12'd0;
    int          en_cnt [4];
    int          gap_bad;
    int          order_bad;

    always #5 clk = ~clk;

    // Stage timer: counter runs while any enable is high, done flag when it equals the threshold
    always @(posedge clk) tcnt <= (|en_o) ? tcnt + 12'd1 : 12'd0;
    assign to_i = ({en_o[3] && tcnt == 12'd1085, en_o[2] && tcnt == 12'd1,
                    en_o[1] && tcnt == 12'd31,   en_o[0] && tcnt == 12'd70} & model_mask) | to_force;

    cnn_stage_sequencer #(.GAP_CYCLES(2), .WDOG_CYCLES(2047), .WDOG_W(12)) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rstn),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .abort          (abort),
        .to_i           (to_i),
        .en_o           (en_o),
        .stage_o        (stage_o),
        .busy           (busy),
        .m_done_valid   (m_done_valid),
        .m_done_ready   (m_done_ready),
        .m_done_err     (m_done_err)
`ifdef CNN_SEQ_PERF_EN
        ,
        .perf_cycles    (perf_cycles)
`endif
    );

    function automatic int oh_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    // Walks the frame from the current cycle until m_done_valid, tallying enables and gaps
    task automatic run_until_done(input int budget, output bit ok);
        logic [3:0] prev;
        int zrun;
        int last_idx;
        int idx;
        for (int k = 0; k < 4; k++) en_cnt[k] = 0;
        gap_bad = 0;
        order_bad = 0;
        zrun = 0;
        prev = 4'b0;
        last_idx = oh_idx(en_o) - 1;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (m_done_valid) begin
                ok = 1'b1;
                return;
            end
            idx = oh_idx(en_o);
            if (en_o != 4'b0) begin
                if (idx < 0) order_bad++;
                else begin
                    en_cnt[idx]++;
                    if (stage_o != 3'(idx + 1)) order_bad++;
                    if (prev == 4'b0) begin
                        if (n > 0 && zrun != 2) gap_bad++;
                        if (idx != last_idx + 1) order_bad++;
                        last_idx = idx;
                    end else if (prev != en_o) order_bad++;
                end
                zrun = 0;
            end else begin
                zrun++;
                if (stage_o != 3'd0) order_bad++;
            end
            prev = en_o;
            step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start_valid = 1'b1;
        repeat (3) step();
        checks++;
        if ({start_ready, en_o, stage_o, busy, m_done_valid, m_done_err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b en=%b stg=%0d busy=%b v=%b e=%b, want all 0",
                     start_ready, en_o, stage_o, busy, m_done_valid, m_done_err);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (start_ready !== 1'b1 || en_o !== 4'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got rdy=%b en=%b, want rdy=1 en=0000", start_ready, en_o);
        end
        step();
        start_valid = 1'b0;
        checks++;
        if (en_o !== 4'b0001 || stage_o !== 3'd1 || busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_accept: got en=%b stg=%0d busy=%b rdy=%b, want 0001/1/1/0",
                     en_o, stage_o, busy, start_ready);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        bit ok;
        start_frame();
        run_until_done(5000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_frame_timeout: got no done in 5000 cycles, want done");
        end
        checks++;
        if (en_cnt[0] != 71 || en_cnt[1] != 32 || en_cnt[2] != 2 || en_cnt[3] != 1086) begin
            errors++;
            $display("FAIL full_frame_en_lengths: got %0d/%0d/%0d/%0d, want 71/32/2/1086",
                     en_cnt[0], en_cnt[1], en_cnt[2], en_cnt[3]);
        end
        checks++;
        if (gap_bad != 0 || order_bad != 0) begin
            errors++;
            $display("FAIL full_frame_gaps_order: got gap_bad=%0d order_bad=%0d, want 0/0", gap_bad, order_bad);
        end
        checks++;
        if (m_done_valid !== 1'b1 || m_done_err !== 1'b0 || en_o !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_frame_done: got v=%b e=%b en=%b busy=%b, want 1/0/0000/1",
                     m_done_valid, m_done_err, en_o, busy);
        end
`ifdef CNN_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd1197) begin
            errors++;
            $display("FAIL full_frame_perf: got %0d, want 1197", perf_cycles);
        end
`endif
        m_done_ready = 1'b1;
        step();
        m_done_ready = 1'b0;
        checks++;
        if (m_done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_frame_accept: got v=%b busy=%b rdy=%b, want 0/0/1", m_done_valid, busy, start_ready);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        model_mask = 4'b1011;
        start_frame();
        run_until_done(5000, ok);
        model_mask = 4'hF;
        checks++;
        if (!ok || en_cnt[0] != 71 || en_cnt[1] != 32 || en_cnt[2] != 2047 || en_cnt[3] != 0) begin
            errors++;
            $display("FAIL watchdog_lengths: got ok=%0d %0d/%0d/%0d/%0d, want 1 71/32/2047/0",
                     ok, en_cnt[0], en_cnt[1], en_cnt[2], en_cnt[3]);
        end
        checks++;
        if (m_done_valid !== 1'b1 || m_done_err !== 1'b1 || en_o !== 4'b0) begin
            errors++;
            $display("FAIL watchdog_done: got v=%b e=%b en=%b, want 1/1/0000", m_done_valid, m_done_err, en_o);
        end
`ifdef CNN_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd2154) begin
            errors++;
            $display("FAIL watchdog_perf: got %0d, want 2154", perf_cycles);
        end
`endif
    endtask

    task automatic test_done_hold();
        int bad_v = 0;
        int bad_e = 0;
        int bad_o = 0;
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_done_valid !== 1'b1) bad_v++;
            if (m_done_err !== 1'b1) bad_e++;
            if (en_o !== 4'b0 || start_ready !== 1'b0 || busy !== 1'b1) bad_o++;
        end
        start_valid = 1'b0;
        checks++;
        if (bad_v != 0 || bad_e != 0) begin
            errors++;
            $display("FAIL done_hold_stable: got %0d valid and %0d err drops, want 0/0", bad_v, bad_e);
        end
        checks++;
        if (bad_o != 0) begin
            errors++;
            $display("FAIL done_hold_ignore_start: got %0d bad cycles, want 0", bad_o);
        end
        m_done_ready = 1'b1;
        step();
        m_done_ready = 1'b0;
        checks++;
        if (m_done_valid !== 1'b0 || m_done_err !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold_release: got v=%b e=%b rdy=%b busy=%b, want 0/0/1/0",
                     m_done_valid, m_done_err, start_ready, busy);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int beats = 0;
        start_frame();
        while (en_o !== 4'b0010 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (en_o !== 4'b0010) begin
            errors++;
            $display("FAIL abort_reach_run2: got en=%b, want 0010", en_o);
        end
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (en_o !== 4'b0 || busy !== 1'b0 || stage_o !== 3'd0 || m_done_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_run2: got en=%b busy=%b stg=%0d v=%b rdy=%b, want 0000/0/0/0/1",
                     en_o, busy, stage_o, m_done_valid, start_ready);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (m_done_valid !== 1'b0 || en_o !== 4'b0) beats++;
        end
        checks++;
        if (beats != 0) begin
            errors++;
            $display("FAIL abort_no_done_beat: got %0d active cycles, want 0", beats);
        end
`ifdef CNN_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd2154) begin
            errors++;
            $display("FAIL abort_perf_kept: got %0d, want 2154", perf_cycles);
        end
`endif
        start_valid = 1'b1;
        abort = 1'b1;
        step();
        start_valid = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || en_o !== 4'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_with_start: got busy=%b en=%b rdy=%b, want 0/0000/1", busy, en_o, start_ready);
        end
        step();
    endtask

    task automatic test_spurious();
        bit ok;
        int n = 0;
        start_frame();
        repeat (10) step();
        to_force = 4'b1000;
        step();
        to_force = 4'b0000;
        checks++;
        if (en_o !== 4'b0001 || stage_o !== 3'd1) begin
            errors++;
            $display("FAIL spurious_run1: got en=%b stg=%0d, want 0001/1", en_o, stage_o);
        end
        while (en_o !== 4'b0000 && n < 200) begin
            step();
            n++;
        end
        to_force = 4'b1111;
        step();
        checks++;
        if (en_o !== 4'b0000 || busy !== 1'b1 || m_done_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_gap1: got en=%b busy=%b v=%b, want 0000/1/0", en_o, busy, m_done_valid);
        end
        step();
        to_force = 4'b0000;
        checks++;
        if (en_o !== 4'b0010 || stage_o !== 3'd2) begin
            errors++;
            $display("FAIL spurious_next_stage: got en=%b stg=%0d, want 0010/2", en_o, stage_o);
        end
        run_until_done(3000, ok);
        checks++;
        if (!ok || en_cnt[1] != 32 || en_cnt[2] != 2 || en_cnt[3] != 1086 || order_bad != 0 || m_done_err !== 1'b0) begin
            errors++;
            $display("FAIL spurious_rest: got ok=%0d %0d/%0d/%0d order_bad=%0d err=%b, want 1 32/2/1086 0 0",
                     ok, en_cnt[1], en_cnt[2], en_cnt[3], order_bad, m_done_err);
        end
        m_done_ready = 1'b1;
        step();
        m_done_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        start_frame();
        repeat (20) step();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (en_o !== 4'b0 || busy !== 1'b0 || stage_o !== 3'd0 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: got en=%b busy=%b stg=%0d rdy=%b, want 0000/0/0/0",
                     en_o, busy, stage_o, start_ready);
        end
`ifdef CNN_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_midframe_perf: got %0d, want 0", perf_cycles);
        end
`endif
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe_recover: got rdy=%b busy=%b, want 1/0", start_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_watchdog();
        test_done_hold();
        test_abort();
        test_spurious();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
